// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline constants and types for the ID/EX stage.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 12;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [CTRL_W-1:0] ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/hazard_detect_lu.sv
// Load-use hazard detection and front-end write enables (purely combinational).
module hazard_detect_lu
  import mips_pkg::*;
(
  input  logic       ID_Valid,
  input  logic [4:0] ID_RsAddr,
  input  logic [4:0] ID_RtAddr,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic       ID_EX_Valid,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_RegWrAddr,
  input  logic       EX_Flush,
  input  logic       EX_Busy,
  output logic       LoadUseStall,
  output logic       PC_Wr,
  output logic       IF_ID_Wr
);
  logic rs_hit, rt_hit, raw;

  assign rs_hit = ID_UsesRs && (ID_RsAddr == ID_EX_RegWrAddr);
  assign rt_hit = ID_UsesRt && (ID_RtAddr == ID_EX_RegWrAddr);
  // A load targeting $0 produces nothing to wait for.
  assign raw    = ID_Valid && ID_EX_Valid && ID_EX_MemRead &&
                  (ID_EX_RegWrAddr != REG_ZERO) && (rs_hit || rt_hit);

  assign LoadUseStall = raw && !EX_Flush && !EX_Busy;
  // Flush does not gate the PC: the redirect owns it.
  assign PC_Wr        = !(LoadUseStall || EX_Busy);
  assign IF_ID_Wr     = PC_Wr;
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush and EX busy hold.
// Optional saturating perf counters when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage_reg #(
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_Valid,
  input  logic [DATA_W-1:0] ID_PC,
  input  logic [4:0]        ID_RsAddr,
  input  logic [4:0]        ID_RtAddr,
  input  logic              ID_UsesRs,
  input  logic              ID_UsesRt,
  input  logic [4:0]        ID_RegWrAddr,
  input  logic              ID_RegWr,
  input  logic              ID_MemRead,
  input  logic              ID_MemWr,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [DATA_W-1:0] ID_Imm32,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic              EX_Flush,
  input  logic              EX_Busy,
  output logic              ID_EX_Valid,
  output logic [DATA_W-1:0] ID_EX_PC,
  output logic [4:0]        ID_EX_RsAddr,
  output logic [4:0]        ID_EX_RtAddr,
  output logic [4:0]        ID_EX_RegWrAddr,
  output logic              ID_EX_RegWr,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWr,
  output logic [DATA_W-1:0] ID_EX_RsData,
  output logic [DATA_W-1:0] ID_EX_RtData,
  output logic [DATA_W-1:0] ID_EX_Imm32,
  output logic [CTRL_W-1:0] ID_EX_Ctrl,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]       PerfBubbleCnt,
  output logic [31:0]       PerfFlushCnt,
  output logic [31:0]       PerfHoldCnt,
`endif
  output logic              LoadUseStall,
  output logic              PC_Wr,
  output logic              IF_ID_Wr
);
  logic bubble;

  hazard_detect_lu u_hazard (
    .ID_Valid        (ID_Valid),
    .ID_RsAddr       (ID_RsAddr),
    .ID_RtAddr       (ID_RtAddr),
    .ID_UsesRs       (ID_UsesRs),
    .ID_UsesRt       (ID_UsesRt),
    .ID_EX_Valid     (ID_EX_Valid),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_RegWrAddr (ID_EX_RegWrAddr),
    .EX_Flush        (EX_Flush),
    .EX_Busy         (EX_Busy),
    .LoadUseStall    (LoadUseStall),
    .PC_Wr           (PC_Wr),
    .IF_ID_Wr        (IF_ID_Wr)
  );

  // Busy wins over flush, so LoadUseStall already excludes both.
  assign bubble = EX_Flush || LoadUseStall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ID_EX_Valid     <= 1'b0;
      ID_EX_PC        <= '0;
      ID_EX_RsAddr    <= '0;
      ID_EX_RtAddr    <= '0;
      ID_EX_RegWrAddr <= '0;
      ID_EX_RegWr     <= 1'b0;
      ID_EX_MemRead   <= 1'b0;
      ID_EX_MemWr     <= 1'b0;
      ID_EX_RsData    <= '0;
      ID_EX_RtData    <= '0;
      ID_EX_Imm32     <= '0;
      ID_EX_Ctrl      <= '0;
    end else if (!EX_Busy) begin
      if (bubble) begin
        ID_EX_Valid     <= 1'b0;
        ID_EX_PC        <= '0;
        ID_EX_RsAddr    <= mips_pkg::REG_ZERO;
        ID_EX_RtAddr    <= mips_pkg::REG_ZERO;
        ID_EX_RegWrAddr <= mips_pkg::REG_ZERO;
        ID_EX_RegWr     <= 1'b0;
        ID_EX_MemRead   <= 1'b0;
        ID_EX_MemWr     <= 1'b0;
        ID_EX_RsData    <= '0;
        ID_EX_RtData    <= '0;
        ID_EX_Imm32     <= '0;
        ID_EX_Ctrl      <= CTRL_W'(mips_pkg::CTRL_BUBBLE);
      end else begin
        ID_EX_Valid     <= ID_Valid;
        ID_EX_PC        <= ID_PC;
        ID_EX_RsAddr    <= ID_RsAddr;
        ID_EX_RtAddr    <= ID_RtAddr;
        ID_EX_RegWrAddr <= ID_RegWrAddr;
        ID_EX_RegWr     <= ID_RegWr;
        ID_EX_MemRead   <= ID_MemRead;
        ID_EX_MemWr     <= ID_MemWr;
        ID_EX_RsData    <= ID_RsData;
        ID_EX_RtData    <= ID_RtData;
        ID_EX_Imm32     <= ID_Imm32;
        ID_EX_Ctrl      <= ID_Ctrl;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PerfBubbleCnt <= '0;
      PerfFlushCnt  <= '0;
      PerfHoldCnt   <= '0;
    end else begin
      if (LoadUseStall && PerfBubbleCnt != '1)        PerfBubbleCnt <= PerfBubbleCnt + 32'd1;
      if (EX_Flush && !EX_Busy && PerfFlushCnt != '1) PerfFlushCnt  <= PerfFlushCnt + 32'd1;
      if (EX_Busy && PerfHoldCnt != '1)               PerfHoldCnt   <= PerfHoldCnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, load-use stall, $0 load, flush, busy hold, capture.
module tb_id_ex_stage_reg;
  logic        clk = 1'b0;
  logic        reset;
  logic        ID_Valid;
  logic [31:0] ID_PC;
  logic [4:0]  ID_RsAddr, ID_RtAddr, ID_RegWrAddr;
  logic        ID_UsesRs, ID_UsesRt, ID_RegWr, ID_MemRead, ID_MemWr;
  logic [31:0] ID_RsData, ID_RtData, ID_Imm32;
  logic [11:0] ID_Ctrl;
  logic        EX_Flush, EX_Busy;
  logic        ID_EX_Valid, ID_EX_RegWr, ID_EX_MemRead, ID_EX_MemWr;
  logic [31:0] ID_EX_PC, ID_EX_RsData, ID_EX_RtData, ID_EX_Imm32;
  logic [4:0]  ID_EX_RsAddr, ID_EX_RtAddr, ID_EX_RegWrAddr;
  logic [11:0] ID_EX_Ctrl;
  logic        LoadUseStall, PC_Wr, IF_ID_Wr;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] PerfBubbleCnt, PerfFlushCnt, PerfHoldCnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset),
    .ID_Valid(ID_Valid), .ID_PC(ID_PC), .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_RegWrAddr(ID_RegWrAddr),
    .ID_RegWr(ID_RegWr), .ID_MemRead(ID_MemRead), .ID_MemWr(ID_MemWr),
    .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_Imm32(ID_Imm32), .ID_Ctrl(ID_Ctrl),
    .EX_Flush(EX_Flush), .EX_Busy(EX_Busy),
    .ID_EX_Valid(ID_EX_Valid), .ID_EX_PC(ID_EX_PC), .ID_EX_RsAddr(ID_EX_RsAddr),
    .ID_EX_RtAddr(ID_EX_RtAddr), .ID_EX_RegWrAddr(ID_EX_RegWrAddr), .ID_EX_RegWr(ID_EX_RegWr),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWr(ID_EX_MemWr), .ID_EX_RsData(ID_EX_RsData),
    .ID_EX_RtData(ID_EX_RtData), .ID_EX_Imm32(ID_EX_Imm32), .ID_EX_Ctrl(ID_EX_Ctrl),
`ifdef ID_EX_PERF_CNT_EN
    .PerfBubbleCnt(PerfBubbleCnt), .PerfFlushCnt(PerfFlushCnt), .PerfHoldCnt(PerfHoldCnt),
`endif
    .LoadUseStall(LoadUseStall), .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Data/ctrl derived from PC so each instruction carries distinct payload.
  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs, rt,
                        input logic urs, urt, input logic [4:0] wa,
                        input logic rw, mr, mw, input logic [31:0] imm);
    ID_Valid = v; ID_PC = pc; ID_RsAddr = rs; ID_RtAddr = rt;
    ID_UsesRs = urs; ID_UsesRt = urt; ID_RegWrAddr = wa;
    ID_RegWr = rw; ID_MemRead = mr; ID_MemWr = mw; ID_Imm32 = imm;
    ID_RsData = pc ^ 32'h1111_0000; ID_RtData = pc ^ 32'h0000_2222; ID_Ctrl = pc[11:0];
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; EX_Flush = 1'b0; EX_Busy = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    chk("rst_valid", ID_EX_Valid, 1'b0);
    chk("rst_pc", ID_EX_PC, 32'h0);
    chk("rst_pcwr", PC_Wr, 1'b1);
    @(negedge clk); reset = 1'b0;

    // lw $8, 4($29)
    set_id(1'b1, 32'h100, 5'd29, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 32'h4);
    tick();
    chk("lw_valid", ID_EX_Valid, 1'b1);
    chk("lw_memrd", ID_EX_MemRead, 1'b1);
    chk("lw_wa", ID_EX_RegWrAddr, 5'd8);
    chk("lw_ctrl", ID_EX_Ctrl, 12'h100);
    // add $9,$8,$1
    set_id(1'b1, 32'h104, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("lu_stall", LoadUseStall, 1'b1);
    chk("lu_pcwr", PC_Wr, 1'b0);
    chk("lu_ifid", IF_ID_Wr, 1'b0);
    tick();
    chk("bub_valid", ID_EX_Valid, 1'b0);
    chk("bub_regwr", ID_EX_RegWr, 1'b0);
    chk("bub_pc", ID_EX_PC, 32'h0);
    chk("bub_nostall", LoadUseStall, 1'b0);
    chk("bub_pcwr", PC_Wr, 1'b1);
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_bub1", PerfBubbleCnt, 32'd1);
`endif
    tick();
    chk("add_valid", ID_EX_Valid, 1'b1);
    chk("add_rs", ID_EX_RsAddr, 5'd8);
    chk("add_wa", ID_EX_RegWrAddr, 5'd9);
    chk("add_rsdata", ID_EX_RsData, 32'h1111_0104);

    // lw $0, then reader of $0: no stall
    set_id(1'b1, 32'h108, 5'd29, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h8);
    tick();
    set_id(1'b1, 32'h10C, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("lw0_stall", LoadUseStall, 1'b0);
    chk("lw0_pcwr", PC_Wr, 1'b1);
    tick();
    chk("lw0_capt", ID_EX_PC, 32'h10C);

    // lw $6, then store reading rt=$6: stalls only when UsesRt
    set_id(1'b1, 32'h110, 5'd29, 5'd6, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    set_id(1'b1, 32'h114, 5'd4, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("sw_nort_stall", LoadUseStall, 1'b0);
    ID_UsesRt = 1'b1; #1;
    chk("sw_rt_stall", LoadUseStall, 1'b1);
    ID_Valid = 1'b0; #1;
    chk("inv_nostall", LoadUseStall, 1'b0);
    ID_Valid = 1'b1;
    // Same hazard coinciding with a flush: flush owns the bubble
    EX_Flush = 1'b1; #1;
    chk("fl_stall", LoadUseStall, 1'b0);
    chk("fl_pcwr", PC_Wr, 1'b1);
    tick();
    EX_Flush = 1'b0;
    chk("fl_valid", ID_EX_Valid, 1'b0);
    chk("fl_memrd", ID_EX_MemRead, 1'b0);
    chk("fl_wa", ID_EX_RegWrAddr, 5'd0);
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_fl", PerfFlushCnt, 32'd1);
    chk("perf_bub_fl", PerfBubbleCnt, 32'd1);
`endif

    // addi $2,$0,5 ; sw $3,0($4)
    set_id(1'b1, 32'h200, 5'd0, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 32'd5);
    tick();
    chk("addi_imm", ID_EX_Imm32, 32'd5);
    chk("addi_regwr", ID_EX_RegWr, 1'b1);
    set_id(1'b1, 32'h204, 5'd4, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("sw_stall", LoadUseStall, 1'b0);
    tick();
    chk("sw_memwr", ID_EX_MemWr, 1'b1);
    chk("sw_rt", ID_EX_RtAddr, 5'd3);
    chk("sw_rtdata", ID_EX_RtData, 32'h0000_2026);

    // EX busy for three cycles while ID changes
    EX_Busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h208 + 32'(4*i), 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 32'd9);
      chk("busy_pcwr", PC_Wr, 1'b0);
      chk("busy_ifid", IF_ID_Wr, 1'b0);
      tick();
      chk("busy_hold_pc", ID_EX_PC, 32'h204);
      chk("busy_hold_mw", ID_EX_MemWr, 1'b1);
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_hold", PerfHoldCnt, 32'd3);
`endif
    EX_Busy = 1'b0; #1;
    tick();
    chk("resume_pc", ID_EX_PC, 32'h210);
    chk("resume_memrd", ID_EX_MemRead, 1'b1);
    chk("resume_wa", ID_EX_RegWrAddr, 5'd7);

    // Reset mid-stall (lw $7 in EX, reader of $7 in ID)
    set_id(1'b1, 32'h214, 5'd7, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("pre_rst_stall", LoadUseStall, 1'b1);
    #1 reset = 1'b1; #1;
    chk("arst_valid", ID_EX_Valid, 1'b0);
    chk("arst_regwr", ID_EX_RegWr, 1'b0);
    chk("arst_wa", ID_EX_RegWrAddr, 5'd0);
    chk("arst_stall", LoadUseStall, 1'b0);
    tick();
    @(negedge clk); reset = 1'b0; #1;
    chk("rel_pcwr", PC_Wr, 1'b1);
    chk("rel_valid", ID_EX_Valid, 1'b0);

    // ID_Valid=0: fields captured, Valid stays low
    set_id(1'b0, 32'h300, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h77);
    tick();
    chk("nv_valid", ID_EX_Valid, 1'b0);
    chk("nv_pc", ID_EX_PC, 32'h300);
    chk("nv_imm", ID_EX_Imm32, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register plus load-use hazard detection for the 5-stage MIPS32 pipeline.
- Captures decoded operands and control from ID each cycle and presents the registered ID_EX_* fields to the EX stage and the forwarding unit.
- Inserts a one-cycle bubble on a load-use hazard and freezes the front end (PC, IF/ID) for that cycle.
- Honours EX-stage flush (branch/jump redirect) and an EX busy hold from a multicycle unit.

Parameters:
- CTRL_W, 12, width of the opaque EX/MEM/WB control bundle carried through unchanged.
- DATA_W, 32, register/immediate/PC width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ID_Valid  in  1  ID holds a real instruction
- ID_PC  in  DATA_W  PC of ID instruction
- ID_RsAddr  in  5  source register rs
- ID_RtAddr  in  5  source register rt
- ID_UsesRs  in  1  instruction reads rs
- ID_UsesRt  in  1  instruction reads rt
- ID_RegWrAddr  in  5  destination register
- ID_RegWr  in  1  writes register file
- ID_MemRead  in  1  is a load
- ID_MemWr  in  1  is a store
- ID_RsData  in  DATA_W  register-file rs value
- ID_RtData  in  DATA_W  register-file rt value
- ID_Imm32  in  DATA_W  extended immediate
- ID_Ctrl  in  CTRL_W  remaining control bundle
- EX_Flush  in  1  redirect resolved in EX; kill the instruction in ID
- EX_Busy  in  1  EX cannot accept; hold everything
- ID_EX_Valid, ID_EX_PC, ID_EX_RsAddr, ID_EX_RtAddr, ID_EX_RegWrAddr, ID_EX_RegWr, ID_EX_MemRead, ID_EX_MemWr, ID_EX_RsData, ID_EX_RtData, ID_EX_Imm32, ID_EX_Ctrl  out  (widths as inputs)  registered copies
- LoadUseStall  out  1  combinational; bubble inserted this cycle
- PC_Wr  out  1  combinational; PC may update
- IF_ID_Wr  out  1  combinational; IF/ID may load

Behaviour:
- Reset (asynchronous, any time, including mid-stall): every ID_EX_* register = 0, so ID_EX_Valid=0, RegWr=0, MemRead=0, MemWr=0, RegWrAddr=0. Registers stay 0 until the first clk edge after reset deasserts.
- Hazard condition (combinational, from registered state):
  - raw = ID_Valid & ID_EX_Valid & ID_EX_MemRead & (ID_EX_RegWrAddr != 0) & ((ID_UsesRs & ID_RsAddr == ID_EX_RegWrAddr) | (ID_UsesRt & ID_RtAddr == ID_EX_RegWrAddr)).
  - LoadUseStall = raw & ~EX_Flush & ~EX_Busy.
- Front-end enables:
  - PC_Wr = IF_ID_Wr = ~(LoadUseStall | EX_Busy).
  - EX_Flush does not gate PC_Wr; the redirect owns the PC.
- Register update at each rising edge, priority highest first:
  1. EX_Busy=1: hold all ID_EX_* (flush deferred; the flush source must hold EX_Flush until Busy drops).
  2. EX_Flush=1: load bubble.
  3. LoadUseStall=1: load bubble.
  4. Otherwise: load all ID_* fields; ID_EX_Valid <= ID_Valid.
- Bubble: Valid, RegWr, MemRead, MemWr = 0; RegWrAddr = 0; data, PC, Ctrl and source addresses = 0.
- Latency: one cycle ID→EX. A load-use stall lasts exactly one cycle, because the bubble clears ID_EX_MemRead. Load followed by a dependent instruction therefore costs one bubble, after which the dependence is satisfied by MEM/WB forwarding.
- ID_Valid=0 with no flush, busy or stall: ID_EX_Valid=0 and all other fields captured as-is. Downstream must qualify with Valid and RegWr.
- A load writing $0 never stalls.
- A store whose rt depends on the load stalls only if ID_UsesRt is set (the decoder sets it for stores).

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds three outputs:
  - PerfBubbleCnt (32 bits): counts cycles with LoadUseStall=1.
  - PerfFlushCnt (32 bits): counts edges where a flush bubble loads.
  - PerfHoldCnt (32 bits): counts EX_Busy cycles.
- All three saturate at 0xFFFFFFFF and clear on reset.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (mips_pkg): REG_ZERO = 5'd0, DATA_W, CTRL_W, a bubble-constant control value, and the ctrl bundle typedef.
- One sub-module, hazard_detect_lu: purely combinational raw/LoadUseStall/PC_Wr/IF_ID_Wr logic.
- The register bank and perf counters live in the top module.

Test Plan:
- Reset asserted mid-run with ID_EX_Valid=1 and RegWr=1 → all outputs 0 immediately (before the next clk); PC_Wr=1 after release.
- lw $8 in EX, then add $9,$8,$1 in ID (UsesRs=1) → LoadUseStall=1, PC_Wr=IF_ID_Wr=0 for exactly one cycle; next edge ID_EX_Valid=0, RegWr=0; following edge the add is captured with RsAddr=8.
- lw $0 in EX, then dependent instruction reading $0 → LoadUseStall=0; no bubble.
- Load-use hazard with EX_Flush=1 in the same cycle → LoadUseStall=0, PC_Wr=1; bubble loaded by flush; PerfFlushCnt+1, PerfBubbleCnt unchanged.
- EX_Busy=1 for 3 cycles with ID fields changing → ID_EX_* unchanged, PC_Wr=IF_ID_Wr=0 for all three cycles; PerfHoldCnt=3; capture resumes on the first non-busy edge.
- Independent instructions back-to-back (addi $2,$0,5; sw $3,0($4)) → registered fields match ID inputs one cycle later (ID_EX_Imm32=5, MemWr=1 on the second); no stalls.
